config_port_arbiter: RTL
========================

Name: config_port_arbiter

Overview:
Front-end scheduler for the configuration FSM's write port. It shares the single 32-bit WriteData/WriteStrobe port between a byte-serial source (UART receiver) and a 32-bit parallel host source. Whichever source first presents the sync word 0xFAB0_FAB1 gets the port, and keeps it until the bitstream desyncs or goes idle. It drives ComActive, which feeds the FSM's Reset input, so the FSM is cleanly re-armed on every new session.

Parameters:
- SYNC_WORD, 32'hFAB0_FAB1: session-start pattern.
- DESYNC_FLAG, 20: header bit index that ends a session.
- FRAME_WORDS, 12: data words per frame (equals NumberOfRows).
- TIMEOUT_W, 12: idle-timeout counter width.
- TIMEOUT_CYCLES, 4095: idle cycles before forced release.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- byte_data  in  8  UART byte; most-significant byte first.
- byte_valid  in  1  one-cycle byte strobe; no backpressure.
- word_data  in  32  host word.
- word_valid  in  1  host word valid.
- word_ready  out  1  host word accepted when word_valid and word_ready are both high.
- WriteData  out  32  word to the configuration FSM.
- WriteStrobe  out  1  one-cycle write strobe to the FSM.
- ComActive  out  1  session active; drives the FSM Reset input.
- owner  out  2  current owner: 0 = none, 1 = byte, 2 = word.
- byte_dropped  out  1  sticky; set when a byte arrives while the word source owns the port; cleared by Reset.

Behaviour:
- Reset (any cycle, including mid-session): state IDLE, ComActive=0, WriteStrobe=0, WriteData=0, owner=0, byte_dropped=0, byte window cleared, counters cleared. Any in-flight word is discarded.
- States: IDLE, ARM, OWN.
- IDLE:
  - word_ready=1; accepted words other than SYNC_WORD are dropped.
  - The byte path keeps a sliding 4-byte window (newest byte in bits [7:0]).
  - Lock is taken at edge t, on either an accepted word equal to SYNC_WORD or a byte that makes the window equal SYNC_WORD.
  - If both sources present sync in the same cycle, the word source wins and the byte window is cleared.
  - At lock: ComActive<=1, owner set, byte-lane counter cleared, state ARM.
- ARM (edges t+1, t+2):
  - word_ready=0; bytes are still collected into the aligned lane counter.
  - At edge t+2: WriteData=SYNC_WORD, WriteStrobe=1 for one cycle. This gives the FSM one edge to see the ComActive rising edge before the sync word.
  - Then state OWN, phase=HEADER.
- OWN, byte owner:
  - Each group of 4 bytes, aligned from lock, forms one word, MSB first.
  - WriteStrobe is pulsed one cycle after the 4th byte.
  - word_ready=0.
- OWN, word owner:
  - word_ready=1.
  - An accepted word is presented on WriteData with WriteStrobe one cycle later.
  - Any byte_valid sets byte_dropped.
- Phase tracking, applied to each forwarded word:
  - HEADER with DESYNC_FLAG bit = 1: forward the word. Next edge: ComActive=0, owner=0, state IDLE, byte window cleared.
  - HEADER with DESYNC_FLAG bit = 0: phase=DATA, data counter=FRAME_WORDS.
  - DATA: decrement the counter; at 1, return to HEADER.
- WriteData holds its last value when WriteStrobe=0.
- WriteStrobe is never high on two consecutive cycles from the byte path; the word path may strobe every cycle.
- Data arriving on the same edge as a release is dropped.

Optional Feature:
CFG_ARB_TIMEOUT_EN
- Defined:
  - In OWN, a TIMEOUT_W-bit counter clears on every owner byte or word and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: release exactly as for desync, with no strobe issued. A partial byte word is discarded.
- Undefined: the counter is absent; a session is released only by desync or Reset.

Decomposition:
- Shared package cfg_arb_pkg holds:
  - the state enum (IDLE/ARM/OWN);
  - the owner encoding (NONE=0, BYTE=1, WORD=2);
  - the phase enum (HEADER/DATA);
  - the SYNC_WORD constant.
- One natural sub-module, cfg_byte_packer: sliding sync window, aligned 4-byte packing and the word-complete pulse.

Test Plan:
1. Host sends 0xFAB0_FAB1, header 0x0000_0003, 12 data words, header 0x0010_0000 -> ComActive rises one edge after sync. Sync strobed two edges later, then 14 strobes with matching data. ComActive falls one edge after the desync header is forwarded; owner returns to 0.
2. UART sends junk bytes 0x11 0xFA 0xB0 0xFA 0xB1, then header bytes 00 00 00 05 -> lock on the 5th byte. WriteData=0x0000_0005 strobed one cycle after the last header byte.
3. Sync word and the final sync byte arrive in the same cycle -> owner=2, and the byte window is cleared. Later bytes set byte_dropped=1 and produce no strobe.
4. Reset asserted in the middle of a frame, after the 6th data word -> next cycle ComActive=0, owner=0, no further strobes. A fresh sync is accepted afterwards.
5. With CFG_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, byte owner stalls after 2 bytes -> release at idle count 16, with no strobe for the partial word.
6. Host streams 12 back-to-back data words with word_valid held high -> 12 consecutive single-cycle WriteStrobe pulses. word_ready=0 only during the 2 ARM cycles.

Source files
------------

// File: rtl/cfg_arb_pkg.sv
// Shared definitions for config_port_arbiter and its byte packer.
// Contents: arbiter state, owner encoding, frame phase and the default
// session-start pattern.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_BYTE = 2'd1,
        OWNER_WORD = 2'd2
    } owner_e;

    typedef enum logic {
        PH_HEADER = 1'b0,
        PH_DATA   = 1'b1
    } phase_e;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_port_arbiter_if.sv
// Bus bundle between the two configuration sources, the arbiter and the
// configuration FSM write port.
//   master : source/FSM side (drives byte/word inputs, observes outputs)
//   slave  : arbiter side
// Signals: byte_data/byte_valid (UART bytes), word_data/word_valid/
// word_ready (host words), WriteData/WriteStrobe/ComActive (FSM port),
// owner, byte_dropped (status).
interface config_port_arbiter_if;
    import cfg_arb_pkg::*;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    owner_e      owner;
    logic        byte_dropped;

    modport master (
        output byte_data, byte_valid, word_data, word_valid,
        input  word_ready, WriteData, WriteStrobe, ComActive, owner, byte_dropped
    );

    modport slave (
        input  byte_data, byte_valid, word_data, word_valid,
        output word_ready, WriteData, WriteStrobe, ComActive, owner, byte_dropped
    );

endinterface

// File: rtl/cfg_byte_packer.sv
// Byte-serial front end of the arbiter.
// Keeps a shift register of the last three bytes so that, together with the
// incoming byte, it serves both as the sliding sync window and as the
// aligned MSB-first word assembler.
// Ports:
//   CLK, Reset             clock, synchronous active-high reset
//   byte_data, byte_valid  incoming UART byte and strobe
//   win_clear              flush the window (release / word-won tie)
//   lane_clear             restart 4-byte alignment (session lock)
//   lane_en                count bytes into aligned lanes (byte owner)
//   sync_hit               this byte completes the sync pattern
//   word_done              this byte is the 4th of an aligned group
//   packed_word            window plus incoming byte, MSB first
module cfg_byte_packer
    import cfg_arb_pkg::*;
#(
    parameter logic [31:0] SYNC_PATTERN = SYNC_WORD
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        win_clear,
    input  logic        lane_clear,
    input  logic        lane_en,
    output logic        sync_hit,
    output logic        word_done,
    output logic [31:0] packed_word
);

    logic [23:0] win_q, win_d;
    logic [1:0]  lane_q, lane_d;

    always_comb begin
        win_d  = win_q;
        lane_d = lane_q;
        if (byte_valid) begin
            win_d = {win_q[15:0], byte_data};
        end
        if (win_clear) begin
            win_d = '0;
        end
        if (lane_en && byte_valid) begin
            lane_d = lane_q + 2'd1;
        end
        if (lane_clear) begin
            lane_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            win_q  <= '0;
            lane_q <= '0;
        end else begin
            win_q  <= win_d;
            lane_q <= lane_d;
        end
    end

    // The window always shifts, so at the 4th aligned byte it holds exactly
    // the three earlier bytes of the group.
    assign packed_word = {win_q, byte_data};
    assign sync_hit    = byte_valid && (packed_word == SYNC_PATTERN);
    assign word_done   = byte_valid && lane_en && (lane_q == 2'd3);

endmodule

// File: rtl/config_port_arbiter.sv
// Shares the configuration FSM write port between a UART byte source and a
// 32-bit host word source. The first source to present the sync word owns
// the port until a desync header (or, with CFG_ARB_TIMEOUT_EN defined, an
// idle timeout) releases it. ComActive frames each session so the FSM is
// re-armed.
// Optional build macro: CFG_ARB_TIMEOUT_EN (idle-timeout release).
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   port_if      config_port_arbiter_if.slave: byte/word sources, WriteData,
//                WriteStrobe, ComActive, owner, byte_dropped
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; hunting for sync on both sources
//   ARM     | locked; two edges for the FSM to see ComActive rise, then
//           | the sync word is strobed
//   OWN     | forwarding owner words, tracking header/data phase
module config_port_arbiter
    import cfg_arb_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD      = cfg_arb_pkg::SYNC_WORD,
    parameter int          DESYNC_FLAG    = 20,
    parameter int          FRAME_WORDS    = 12,
    parameter int          TIMEOUT_W      = 12,
    parameter int          TIMEOUT_CYCLES = 4095
) (
    input  logic CLK,
    input  logic Reset,
    config_port_arbiter_if.slave port_if
);

    localparam int DCNT_W = $clog2(FRAME_WORDS + 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    phase_e              phase_q, phase_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                arm_q, arm_d;
    logic                rel_q, rel_d;
    logic                com_q, com_d;
    logic                ws_q, ws_d;
    logic                drop_q, drop_d;
    logic [31:0]         wd_q, wd_d;

    logic                word_ready;
    logic                word_acc;
    logic                fwd;
    logic [31:0]         fwd_word;
    logic                release_now;

    logic                win_clear;
    logic                lane_clear;
    logic                lane_en;
    logic                sync_hit;
    logic                word_done;
    logic [31:0]         packed_word;

`ifdef CFG_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic                 owner_act;
`else
    logic                 unused_timeout;
    assign unused_timeout = ^(TIMEOUT_W'(TIMEOUT_CYCLES));
`endif

    cfg_byte_packer #(
        .SYNC_PATTERN (SYNC_WORD)
    ) u_packer (
        .CLK         (CLK),
        .Reset       (Reset),
        .byte_data   (port_if.byte_data),
        .byte_valid  (port_if.byte_valid),
        .win_clear   (win_clear),
        .lane_clear  (lane_clear),
        .lane_en     (lane_en),
        .sync_hit    (sync_hit),
        .word_done   (word_done),
        .packed_word (packed_word)
    );

    assign word_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_OWN) && (owner_q == OWNER_WORD));
    assign word_acc   = port_if.word_valid && word_ready;
    assign lane_en    = (owner_q == OWNER_BYTE) && (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        phase_d     = phase_q;
        dcnt_d      = dcnt_q;
        arm_d       = arm_q;
        rel_d       = 1'b0;
        com_d       = com_q;
        ws_d        = 1'b0;
        wd_d        = wd_q;
        drop_d      = drop_q;
        win_clear   = 1'b0;
        lane_clear  = 1'b0;
        release_now = 1'b0;
        fwd         = 1'b0;
        fwd_word    = packed_word;
`ifdef CFG_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        owner_act   = 1'b0;
`endif

        if ((owner_q == OWNER_WORD) && port_if.byte_valid) begin
            drop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Word source wins a same-cycle tie; its lock flushes the
                // byte window so the losing byte stream restarts cleanly.
                if (word_acc && (port_if.word_data == SYNC_WORD)) begin
                    owner_d   = OWNER_WORD;
                    win_clear = 1'b1;
                    state_d   = ST_ARM;
                end else if (sync_hit) begin
                    owner_d = OWNER_BYTE;
                    state_d = ST_ARM;
                end
                if (state_d == ST_ARM) begin
                    com_d      = 1'b1;
                    lane_clear = 1'b1;
                    arm_d      = 1'b0;
                    phase_d    = PH_HEADER;
                    dcnt_d     = '0;
                end
            end

            ST_ARM: begin
                if (!arm_q) begin
                    arm_d = 1'b1;
                end else begin
                    wd_d    = SYNC_WORD;
                    ws_d    = 1'b1;
                    state_d = ST_OWN;
                    phase_d = PH_HEADER;
`ifdef CFG_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end

            ST_OWN: begin
                // rel_q: desync header went out last edge; anything arriving
                // now is dropped along with the session.
                if (rel_q) begin
                    release_now = 1'b1;
                end else begin
                    if (owner_q == OWNER_BYTE) begin
                        fwd      = word_done;
                        fwd_word = packed_word;
`ifdef CFG_ARB_TIMEOUT_EN
                        owner_act = port_if.byte_valid;
`endif
                    end else begin
                        fwd      = word_acc;
                        fwd_word = port_if.word_data;
`ifdef CFG_ARB_TIMEOUT_EN
                        owner_act = word_acc;
`endif
                    end

                    if (fwd) begin
                        wd_d = fwd_word;
                        ws_d = 1'b1;
                        if (phase_q == PH_HEADER) begin
                            if (fwd_word[DESYNC_FLAG]) begin
                                rel_d = 1'b1;
                            end else begin
                                phase_d = PH_DATA;
                                dcnt_d  = DCNT_W'(FRAME_WORDS);
                            end
                        end else if (dcnt_q == DCNT_W'(1)) begin
                            phase_d = PH_HEADER;
                        end else begin
                            dcnt_d = dcnt_q - DCNT_W'(1);
                        end
                    end

`ifdef CFG_ARB_TIMEOUT_EN
                    if (owner_act) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        release_now = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (release_now) begin
            state_d   = ST_IDLE;
            com_d     = 1'b0;
            owner_d   = OWNER_NONE;
            win_clear = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_NONE;
            phase_q <= PH_HEADER;
            dcnt_q  <= '0;
            arm_q   <= 1'b0;
            rel_q   <= 1'b0;
            com_q   <= 1'b0;
            ws_q    <= 1'b0;
            wd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            phase_q <= phase_d;
            dcnt_q  <= dcnt_d;
            arm_q   <= arm_d;
            rel_q   <= rel_d;
            com_q   <= com_d;
            ws_q    <= ws_d;
            wd_q    <= wd_d;
            drop_q  <= drop_d;
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign port_if.word_ready   = word_ready;
    assign port_if.WriteData    = wd_q;
    assign port_if.WriteStrobe  = ws_q;
    assign port_if.ComActive    = com_q;
    assign port_if.owner        = owner_q;
    assign port_if.byte_dropped = drop_q;

endmodule
